// File: rtl/prog_rom_if.sv
// Boot-load, fetch-request and fetch-response signals of the program ROM.
// The slave modport is the ROM side; the master modport is the loader/fetcher side.
interface prog_rom_if #(
    parameter int DATA_W = 34,
    parameter int PC_W   = 32
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              req_valid;
    logic [PC_W-1:0]   req_pc;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              rsp_ready;
    logic              flush;
    logic              booted;

    modport slave (
        input  ld_valid, ld_data, ld_last, req_valid, req_pc, rsp_ready, flush,
        output ld_ready, req_ready, rsp_valid, rsp_data, rsp_err, booted
    );

    modport master (
        output ld_valid, ld_data, ld_last, req_valid, req_pc, rsp_ready, flush,
        input  ld_ready, req_ready, rsp_valid, rsp_data, rsp_err, booted
    );
endinterface

// File: rtl/prog_rom.sv
// Boot-loadable program ROM: filled word by word in BOOT, then serves
// single-cycle-latency instruction fetches by byte address in RUN.
module prog_rom #(
    parameter int                DATA_W   = 34,
    parameter int                DEPTH    = 64,
    parameter int                AW       = $clog2(DEPTH),
    parameter int                PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    prog_rom_if.slave bus
);
    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [AW-1:0]     r_ld_ptr;
    logic [DEPTH-1:0]  r_written;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic              w_ld_fire;
    logic              w_ld_done;
    logic [AW-1:0]     w_idx;
    logic              w_aligned;
    logic              w_in_range;
    logic              w_err;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_req_ready;
    logic              w_req_fire;

    assign w_ld_fire  = (r_state == ST_BOOT) && bus.ld_valid;
    assign w_ld_done  = bus.ld_last || (r_ld_ptr == AW'(DEPTH - 1));

    assign w_idx      = bus.req_pc[AW+1:2];
    assign w_aligned  = (bus.req_pc[1:0] == 2'b00);
    assign w_in_range = (bus.req_pc[PC_W-1:AW+2] == '0);
    assign w_err      = !(w_aligned && w_in_range);
    // Per-word written flags make never-loaded words read as zero without clearing the array.
    assign w_rd_word  = r_written[w_idx] ? r_mem[w_idx] : '0;

    assign w_req_ready = (r_state == ST_RUN) && (!r_rsp_valid || bus.rsp_ready) && !bus.flush;
    assign w_req_fire  = bus.req_valid && w_req_ready;

    always_ff @(posedge clk) begin
        if (w_ld_fire) begin
            r_mem[r_ld_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_BOOT;
            r_ld_ptr  <= '0;
            r_written <= '0;
        end else if (w_ld_fire) begin
            r_written[r_ld_ptr] <= 1'b1;
            r_ld_ptr            <= r_ld_ptr + 1'b1;
            if (w_ld_done) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Flush wins over everything; otherwise a new fetch replaces a consumed response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (bus.flush) begin
            r_rsp_valid <= 1'b0;
        end else if (w_req_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_err ? NOP_WORD : w_rd_word;
            r_rsp_err   <= w_err;
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.ld_ready  = (r_state == ST_BOOT);
    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.booted    = (r_state == ST_RUN);
endmodule
